// File: rtl/multicycle_uc.sv
// Control unit for a multicycle MIPS-style datapath. The FSM state is registered, and the outputs are decoded from that state plus mem_ready.
// Only FETCH, MEMRD and MEMWR can stall: each waits for mem_ready; every other state lasts one cycle.
module multicycle_uc #(
  parameter int ALUOP_W    = 4,
  parameter int EN_BITSWAP = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               irWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         pcSource,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_BITSWAP = 6'b011111;

  state_t           state_q;
  logic [5:0]       op_q;
  logic [3:0]       aluop_q;
  logic [CNT_W-1:0] cnt_q;

  state_t     dec_next;
  logic [3:0] dec_aluop;
  logic       is_r;

  always_comb begin
    dec_next  = S_ILLEGAL;
    dec_aluop = 4'b0000;
    case (opcode)
      6'b100011, 6'b101011: dec_next = S_MEMADR;
      6'b000000: begin dec_next = S_EXEC; dec_aluop = 4'b0010; end
      6'b001111: begin dec_next = S_EXEC; dec_aluop = 4'b1001; end
      6'b001000, 6'b001001: dec_next = S_EXEC;
      6'b001100: begin dec_next = S_EXEC; dec_aluop = 4'b0100; end
      6'b001101: begin dec_next = S_EXEC; dec_aluop = 4'b0101; end
      6'b001110: begin dec_next = S_EXEC; dec_aluop = 4'b0111; end
      6'b001010, 6'b001011: begin dec_next = S_EXEC; dec_aluop = 4'b0110; end
      6'b011111: begin
        if (EN_BITSWAP != 0) begin
          dec_next  = S_EXEC;
          dec_aluop = 4'b1111;
        end
      end
      6'b000011: begin dec_next = S_BRANCH; dec_aluop = 4'b1000; end
      6'b000100: begin dec_next = S_BRANCH; dec_aluop = 4'b0001; end
      6'b000001: begin dec_next = S_BRANCH; dec_aluop = 4'b0011; end
      6'b000101: begin dec_next = S_BRANCH; dec_aluop = 4'b1011; end
      6'b000010: dec_next = S_JUMP;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      aluop_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= opcode;
          aluop_q <= dec_aluop;
          state_q <= dec_next;
        end
        S_MEMADR: state_q <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWR: begin
          if (mem_ready) begin
            state_q <= S_FETCH;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_EXEC:   state_q <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
          state_q <= S_FETCH;
          cnt_q   <= cnt_q + 1'b1;
        end
        // ILLEGAL and the unused codes 11-15 return to FETCH without retiring.
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign is_r = (op_q == OP_RTYPE) || (op_q == OP_BITSWAP);

  logic [3:0] alu4;
  logic       pw_raw, pwc_raw, irw_raw, mwr_raw, rw_raw, ill_raw;

  always_comb begin
    pw_raw   = 1'b0;
    pwc_raw  = 1'b0;
    irw_raw  = 1'b0;
    mwr_raw  = 1'b0;
    rw_raw   = 1'b0;
    ill_raw  = 1'b0;
    iorD     = 1'b0;
    memRead  = 1'b0;
    memToReg = 1'b0;
    regDst   = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    pcSource = 2'b00;
    alu4     = 4'b0000;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irw_raw = mem_ready;
        pw_raw  = mem_ready;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEMADR: begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
      S_MEMRD:  begin memRead = 1'b1; iorD = 1'b1; end
      S_MEMWB:  begin rw_raw = 1'b1; memToReg = 1'b1; end
      S_MEMWR:  begin mwr_raw = 1'b1; iorD = 1'b1; end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = is_r ? 2'b00 : 2'b10;
        alu4    = aluop_q;
      end
      S_ALUWB:  begin rw_raw = 1'b1; regDst = is_r; end
      S_BRANCH: begin
        aluSrcA  = 1'b1;
        pcSource = 2'b01;
        alu4     = aluop_q;
        pwc_raw  = 1'b1;
      end
      S_JUMP:    begin pw_raw = 1'b1; pcSource = 2'b10; end
      S_ILLEGAL: ill_raw = 1'b1;
      default: ;
    endcase
  end

  // Writes are masked combinationally so nothing commits while reset is held.
  assign pcWrite     = pw_raw  & ~rst;
  assign pcWriteCond = pwc_raw & ~rst;
  assign irWrite     = irw_raw & ~rst;
  assign memWrite    = mwr_raw & ~rst;
  assign regWrite    = rw_raw  & ~rst;
  assign illegal     = ill_raw & ~rst;
  assign aluOp       = ALUOP_W'(alu4);
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_uc.sv
// Bench for multicycle_uc: random instruction streams checked against an instruction-level path/control model.
module tb_multicycle_uc;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_J, K_ILL} kind_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic        rst, mem_ready;
  logic [5:0]  opcode;
  logic        pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite, memToReg, regDst, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, pcSource;
  logic [5:0]  aluOp;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] instr_count;

  multicycle_uc #(.ALUOP_W(6), .EN_BITSWAP(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .irWrite(irWrite),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .aluOp(aluOp), .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  logic        rst2, mr2;
  logic [5:0]  op2;
  logic        pw2, pwc2, iord2, irw2, mrd2, mwr2, m2r2, rdst2, rw2, asa2;
  logic [1:0]  asb2, pcs2;
  logic [3:0]  alu2;
  logic [3:0]  state2;
  logic        ill2;
  logic [1:0]  cnt2;

  multicycle_uc #(.ALUOP_W(4), .EN_BITSWAP(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .opcode(op2), .mem_ready(mr2),
    .pcWrite(pw2), .pcWriteCond(pwc2), .iorD(iord2), .irWrite(irw2),
    .memRead(mrd2), .memWrite(mwr2), .memToReg(m2r2), .regDst(rdst2),
    .regWrite(rw2), .aluSrcA(asa2), .aluSrcB(asb2), .pcSource(pcs2),
    .aluOp(alu2), .state(state2), .illegal(ill2), .instr_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000, 6'b011111: return K_R;
      6'b001111, 6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010, 6'b001011: return K_I;
      6'b000011, 6'b000100, 6'b000001, 6'b000101: return K_BR;
      6'b000010: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input logic [5:0] op);
    case (op)
      6'b000000: return 4'b0010;
      6'b001111: return 4'b1001;
      6'b011111: return 4'b1111;
      6'b001100: return 4'b0100;
      6'b001101: return 4'b0101;
      6'b001110: return 4'b0111;
      6'b001010, 6'b001011: return 4'b0110;
      6'b000011: return 4'b1000;
      6'b000100: return 4'b0001;
      6'b000001: return 4'b0011;
      6'b000101: return 4'b1011;
      default: return 4'b0000;
    endcase
  endfunction

  // {pcWrite,pcWriteCond,iorD,irWrite,memRead,memWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,pcSource,aluOp[5:0],illegal}
  function automatic logic [20:0] ctl_exp(input int st, input kind_t k, input logic [3:0] code, input logic mr);
    logic pw, pwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [3:0] op;
    {pw, pwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; op = 4'b0000;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; asb = (k == K_R) ? 2'b00 : 2'b10; op = code; end
      7:  begin rw = 1; rdst = (k == K_R); end
      8:  begin asa = 1; pcs = 2'b01; op = code; pwc = 1; end
      9:  begin pw = 1; pcs = 2'b10; end
      10: ill = 1;
      default: ;
    endcase
    return {pw, pwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, asb, pcs, 2'b00, op, ill};
  endfunction

  int exp_cnt = 0;

  // Called just after a falling edge; returns just after a falling edge.
  // stall < 0 randomises mem_ready in wait states, otherwise each wait state stalls exactly that many cycles.
  task automatic run_instr(input logic [5:0] op, input int stall);
    kind_t k = kind_of(op);
    logic [3:0] code = code_of(op);
    int path[$];
    int idx = 0;
    int nst = 0;
    int st;
    logic mr, wait_st;
    path = {0, 1};
    case (k)
      K_LW:    begin path.push_back(2); path.push_back(3); path.push_back(4); end
      K_SW:    begin path.push_back(2); path.push_back(5); end
      K_R, K_I: begin path.push_back(6); path.push_back(7); end
      K_BR:    path.push_back(8);
      K_J:     path.push_back(9);
      default: path.push_back(10);
    endcase
    while (idx < path.size()) begin
      st = path[idx];
      wait_st = (st == 0 || st == 3 || st == 5);
      if (wait_st) mr = (stall >= 0) ? (nst >= stall) : ($urandom_range(0, 3) != 0);
      else mr = 1'($urandom_range(0, 1));
      mem_ready = mr;
      opcode = (st == 1) ? op : 6'($urandom());
      #1;
      check("state", 32'(state), 32'(st));
      check("ctl", 32'({pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite, memToReg, regDst,
                        regWrite, aluSrcA, aluSrcB, pcSource, aluOp, illegal}),
            32'(ctl_exp(st, k, code, mr)));
      check("instr_count", 32'(instr_count), 32'(exp_cnt));
      @(posedge clk);
      if (wait_st && !mr) nst++;
      else begin idx++; nst = 0; end
      @(negedge clk);
    end
    if (k != K_ILL) exp_cnt = (exp_cnt + 1) & 32'hFFFF;
  endtask

  task automatic step2(input logic [5:0] op, input int st, input logic ill, input int cnt);
    op2 = op;
    #1;
    check("b_state", 32'(state2), 32'(st));
    check("b_illegal", 32'(ill2), 32'(ill));
    check("b_count", 32'(cnt2), 32'(cnt));
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] legal_ops [16] = '{6'b100011, 6'b101011, 6'b000000, 6'b001111, 6'b001000, 6'b001001,
                                 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011, 6'b011111,
                                 6'b000011, 6'b000100, 6'b000001, 6'b000101};

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b0;
    rst2 = 1'b1; mr2 = 1'b1; op2 = 6'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_writes", 32'({pcWrite, pcWriteCond, irWrite, memWrite, regWrite, illegal}), 32'd0);
    rst = 1'b0;

    run_instr(6'b100011, 0);
    run_instr(6'b101011, 3);
    run_instr(6'b000101, 0);
    run_instr(6'b000010, 0);
    run_instr(6'b011111, 0);
    run_instr(6'b111111, 0);
    run_instr(6'b100011, 2);
    for (int i = 0; i < 250; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 15)];
      else op = 6'($urandom());
      run_instr(op, -1);
    end

    // Reset while MEMRD is waiting on memory.
    mem_ready = 1'b1; opcode = 6'b100011;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    mem_ready = 1'b0;
    #1;
    check("memrd_wait", 32'(state), 32'd3);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_writes", 32'({pcWrite, pcWriteCond, irWrite, memWrite, regWrite, illegal}), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_count", 32'(instr_count), 32'd0);
    exp_cnt = 0;
    run_instr(6'b000000, 0);
    run_instr(6'b001101, 1);
    #1;
    check("final_count", 32'(instr_count), 32'(exp_cnt));

    // Second instance: bitswap disabled, 2-bit counter.
    @(negedge clk);
    rst2 = 1'b0;
    step2(6'b0, 0, 1'b0, 0);
    step2(6'b011111, 1, 1'b0, 0);
    step2(6'b0, 10, 1'b1, 0);
    step2(6'b0, 0, 1'b0, 0);
    for (int j = 0; j < 4; j++) begin
      step2(6'b000010, 1, 1'b0, j);
      step2(6'b0, 9, 1'b0, j);
      step2(6'b0, 0, 1'b0, (j + 1) % 4);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
